// File: rtl/mode_sequencer_if.sv
// Request/status bundle between a mode requester and mode_sequencer.
// The requester owns the master modport; the sequencer owns the slave modport.
interface mode_sequencer_if #(
    parameter int MODE_W = 2,
    parameter int OUT_W  = 2,
    parameter int NUM_W  = 3
) ();
    logic              req_valid;
    logic [MODE_W-1:0] req_mode;
    logic              req_ready;
    logic              abort;
    logic [MODE_W-1:0] mode;
    logic [OUT_W-1:0]  out;
    logic [NUM_W-1:0]  out_num;
    logic              err;

    modport master (
        output req_valid, req_mode, abort,
        input  req_ready, mode, out, out_num, err
    );

    modport slave (
        input  req_valid, req_mode, abort,
        output req_ready, mode, out, out_num, err
    );
endinterface

// File: rtl/mode_sequencer.sv
// Mode register with dwell guard and table decode; transitions land 1 cycle after acceptance.
// req_ready stays low until the mode has dwelt MIN_DWELL cycles or while abort is high; requests are not queued.
module mode_sequencer #(
    parameter int                         NUM_MODES  = 4,
    parameter int                         OUT_W      = 2,
    parameter logic [NUM_MODES*OUT_W-1:0] OUT_TABLE  = 8'h2D,
    parameter int                         RESET_MODE = 0,
    parameter int                         NUM_W      = 3,
    parameter int                         MIN_DWELL  = 4
) (
    input  logic              clk,
    input  logic              rst,
    mode_sequencer_if.slave   bus
);
    localparam int MODE_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1;

    logic [MODE_W-1:0] mode_q, mode_d;
    logic [NUM_W-1:0]  out_num_q, out_num_d;
    logic              err_q, err_d;

    logic              ready;
    logic              accept;
    logic              req_oor;
    logic [NUM_W-1:0]  num_inc;
    logic [OUT_W-1:0]  out_dec;

    // Compared as int so the range checks stay meaningful for any parameter set.
    assign ready   = !bus.abort && (int'(out_num_q) >= MIN_DWELL);
    assign accept  = bus.req_valid && ready;
    assign req_oor = int'(bus.req_mode) >= NUM_MODES;
    assign num_inc = (out_num_q == {NUM_W{1'b1}}) ? out_num_q : out_num_q + 1'b1;

    always_comb begin
        mode_d    = mode_q;
        out_num_d = num_inc;
        err_d     = 1'b0;
        if (bus.abort) begin
            mode_d    = MODE_W'(RESET_MODE);
            out_num_d = '0;
        end else if (accept) begin
            if (req_oor) begin
                err_d = 1'b1;
            end else if (bus.req_mode != mode_q) begin
                mode_d    = bus.req_mode;
                out_num_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= MODE_W'(RESET_MODE);
            out_num_q <= '0;
            err_q     <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            out_num_q <= out_num_d;
            err_q     <= err_d;
        end
    end

    // Codes with no table entry decode to zero.
    always_comb begin
        out_dec = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (mode_q == MODE_W'(i)) out_dec = OUT_TABLE[i*OUT_W +: OUT_W];
        end
    end

    assign bus.req_ready = ready;
    assign bus.mode      = mode_q;
    assign bus.out       = out_dec;
    assign bus.out_num   = out_num_q;
    assign bus.err       = err_q;
endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Parametrised mode state machine with a valid/ready request handshake, a minimum-dwell guard, a per-mode output decode table and a saturating dwell counter. It generalises the fixed two-state on/off switch to NUM_MODES modes with programmable output encodings. It sits between a control/config source and the datapath blocks that consume the decoded mode word.

## Interface
- NUM_MODES, 4: number of modes, at least 2; MODE_W = max(1, clog2(NUM_MODES)) is a localparam.
- OUT_W, 2: width of the decoded output word.
- OUT_TABLE, 8'h2D: packed NUM_MODES*OUT_W table; mode i drives OUT_TABLE[i*OUT_W +: OUT_W]. Default gives mode0=1, mode1=3, mode2=2, mode3=0.
- RESET_MODE, 0: mode entered on reset and on abort; must be < NUM_MODES.
- NUM_W, 3: width of out_num.
- MIN_DWELL, 4: cycles a mode is held before a new request is accepted; 0 ≤ MIN_DWELL ≤ 2^NUM_W−1.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- req_valid  in  1  mode-change request valid.
- req_mode  in  MODE_W  requested mode.
- req_ready  out  1  request accepted this cycle if req_valid=1.
- abort  in  1  force return to RESET_MODE; highest priority.
- mode  out  MODE_W  current mode register.
- out  out  OUT_W  decoded output word, combinational from mode.
- out_num  out  NUM_W  saturating count of cycles spent in the current mode.
- err  out  1  one-cycle pulse: an out-of-range request was accepted.

## Operation
- State: mode (MODE_W), out_num (NUM_W), err (1). No other storage.
- req_ready = !abort && (out_num >= MIN_DWELL). accept = req_valid && req_ready.
- Priority per edge: abort > accept > hold.
- abort=1: mode ← RESET_MODE, out_num ← 0, err ← 0. This applies even if already in RESET_MODE. No request is accepted.
- accept, req_mode ≥ NUM_MODES: mode unchanged, out_num keeps counting, err ← 1.
- accept, req_mode == mode: no transition, out_num keeps counting, err ← 0.
- accept, other valid mode: mode ← req_mode, out_num ← 0, err ← 0.
- Hold (no accept, no abort): out_num ← out_num+1, saturating at 2^NUM_W−1. err ← 0.
- out is a full case decode on mode using OUT_TABLE. Unreachable codes (mode ≥ NUM_MODES) decode to 0.
- Requesters hold req_valid/req_mode stable until accepted. The block does not queue requests.

## Timing
- Reset (rst=0, asynchronous): mode=RESET_MODE, out_num=0, err=0, out=OUT_TABLE[RESET_MODE]. req_ready = (MIN_DWELL==0), or 0 while abort=1.
- Reset release is synchronous to the clock; the first update happens on the first rising edge with rst=1.
- Transition latency is 1: a request accepted at edge N gives new mode/out and out_num=0 after edge N.
- req_ready rises after MIN_DWELL hold cycles in a mode. Minimum spacing between effective transitions is MIN_DWELL+1 cycles; with MIN_DWELL=0 it is one transition per cycle.
- err is registered: high for exactly one cycle after the accepting edge.
- Reset asserted mid-dwell or mid-handshake clears state immediately, without a clock edge. A pending request is dropped.
- abort and req_valid in the same cycle: abort wins, req_ready=0, and the request remains pending.

## Test plan
- Reset with defaults -> mode=0, out=2'h1, out_num=0, req_ready=0. After 4 idle cycles req_ready=1. out_num saturates at 3'h7.
- After dwell, req_valid=1, req_mode=1 for one cycle -> next cycle mode=1, out=2'h3, out_num=0, req_ready=0 for 4 cycles. Then req_mode=3 -> out=2'h0.
- req_valid=1, req_mode=2 held from the first cycle after a transition -> accepted only at out_num=4. out=2'h2 on the following cycle; no earlier change.
- NUM_MODES=3, OUT_TABLE=6'h2D: accepted req_mode=3 -> err=1 for one cycle, mode unchanged, out_num not cleared.
- In mode 2 with out_num=2, assert abort together with req_valid (req_mode=1) -> mode=0, out=2'h1, out_num=0, req_ready=0. The request is accepted only 4 cycles after abort deasserts.
- Drive rst=0 between clock edges while in mode 3 -> mode=0, out=2'h1, out_num=0, err=0 immediately. Normal operation resumes after release.
